mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the data-memory side of the single-cycle ARM core. Consumes the core's store stream: MemWrite, ALUResult as address, and WriteData.
- Claims a small address window, buffers bytes in a FIFO, and serialises them 8N1 on a tx pin.
- Returns status and divisor through a combinational read port that the top-level read mux merges into ReadData.

---
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by the core's store stream, with a small TX FIFO.
// STATUS and DIV are read back combinationally so the core can sample them in the same cycle.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        sel,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   offset;
  logic [1:0]    reg_idx;
  logic          wr_en;
  logic          wr_data;
  logic          wr_status;
  logic          wr_div;
  logic          push_ok;
  logic          pop;
  logic [4:0]    count;
  logic          ovf;
  logic [15:0]   div;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shift;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;
  logic          bit_done;
  logic          busy;
  logic          empty;
  logic          full;
  logic [31:0]   status;
  logic          unused_wdata;

  // Subtracting the base makes addresses below the window wrap high, so one compare decodes it.
  assign offset    = ALUResult - BASE_ADDR;
  assign sel       = (offset < 32'd16);
  assign reg_idx   = offset[3:2];
  assign wr_en     = MemWrite && sel;
  assign wr_data   = wr_en && (reg_idx == 2'd0);
  assign wr_status = wr_en && (reg_idx == 2'd1);
  assign wr_div    = wr_en && (reg_idx == 2'd2);
  assign push_ok   = wr_data && (count < DEPTH_C);
  assign pop       = (state == IDLE) && (count != 5'd0);
  assign empty     = (count == 5'd0);
  assign full      = (count == DEPTH_C);
  assign bit_done  = (baud == 16'd0);
  assign status    = {24'b0, count[3:0], ovf, empty, full, busy};
  assign unused_wdata = ^WriteData[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
      irq <= 1'b1;
    end else begin
      if (wr_status)
        ovf <= 1'b0;
      else if (wr_data && !push_ok)
        ovf <= 1'b1;
      if (wr_div)
        div <= WriteData[15:0];
      irq <= (state == IDLE) && (count == 5'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  // The baud counter reloads from the live divisor, so a DIV write only shapes the next bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift   <= 8'd0;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= div;
          end
        end
        START: begin
          if (bit_done) begin
            baud    <= div;
            bit_idx <= 3'd0;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud    <= div;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (bit_done)
            baud <= div;
          else
            baud <= baud - 16'd1;
        end
        default: baud <= div;
      endcase
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (sel) begin
      case (reg_idx)
        2'd1:    ReadData = status;
        2'd2:    ReadData = {16'b0, div};
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: written bytes go into a scoreboard queue and a
// serial-line receiver drains the frames for in-order comparison.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        sel;
  logic [31:0] ReadData;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  bit         exp_wave[$];
  int         mon_len   = 4;
  bit         mon_en    = 1'b0;
  int         frame_err = 0;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .sel       (sel),
    .ReadData  (ReadData),
    .tx        (tx),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    ALUResult = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    ALUResult = addr;
    #1;
    data = ReadData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    readReg(addr, rd);
    checkOutput(tag, rd, exp);
  endtask

  task automatic addWave(input bit lvl, input int n);
    repeat (n) exp_wave.push_back(lvl);
  endtask

  // Receiver: samples mid-bit from the falling start edge using the bench's own bit length.
  initial begin : rx_monitor
    logic [7:0] b;
    forever begin
      @(negedge tx);
      if (mon_en) begin
        repeat (mon_len / 2) @(posedge clk);
        #1;
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (mon_len) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (mon_len) @(posedge clk);
        #1;
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(b);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] b;

    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;

    repeat (5) begin
      MemWrite  = 1'($urandom);
      ALUResult = BASE + 32'($urandom_range(0, 15));
      WriteData = $urandom;
      tick();
    end
    MemWrite = 1'b0;
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_irq", 32'(irq), 32'd1);
    checkReg("rst_status", BASE + 32'd4, 32'h04);
    checkReg("rst_div", BASE + 32'd8, 32'd433);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_tx", 32'(tx), 32'd1);
    checkOutput("post_rst_irq", 32'(irq), 32'd1);
    checkReg("post_rst_status", BASE + 32'd4, 32'h04);
    checkReg("post_rst_div", BASE + 32'd8, 32'd433);

    $display("[TB] single byte 0x55 at DIV=3");
    applyStimulus(BASE + 32'd8, 32'd3);
    checkReg("div_wr", BASE + 32'd8, 32'd3);
    b = 8'h55;
    applyStimulus(BASE, {24'd0, b});
    checkReg("push_status", BASE + 32'd4, 32'h10);
    checkOutput("push_tx_idle", 32'(tx), 32'd1);
    exp_wave.delete();
    addWave(1'b0, 4);
    for (int i = 0; i < 8; i++) addWave(b[i], 4);
    addWave(1'b1, 4);
    for (int k = 0; k < exp_wave.size(); k++) begin
      logic [31:0] rd;
      tick();
      checkOutput($sformatf("b55_tx[%0d]", k), 32'(tx), 32'(exp_wave[k]));
      readReg(BASE + 32'd4, rd);
      checkOutput($sformatf("b55_busy[%0d]", k), 32'(rd[0]), 32'd1);
      if (k == 20) checkOutput("b55_irq_mid", 32'(irq), 32'd0);
    end
    tick();
    checkReg("b55_idle_status", BASE + 32'd4, 32'h04);
    tick();
    checkOutput("b55_irq_back", 32'(irq), 32'd1);

    $display("[TB] overflow at DIV=100");
    applyStimulus(BASE + 32'd8, 32'd100);
    mon_len = 101;
    mon_en  = 1'b1;
    expq.delete();
    rxq.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      applyStimulus(BASE, {24'd0, b});
    end
    checkReg("ovf_9_status", BASE + 32'd4, 32'h83);
    for (int i = 0; i < 10; i++) applyStimulus(BASE, $urandom);
    checkReg("ovf_19_status", BASE + 32'd4, 32'h8B);
    checkOutput("ovf_irq", 32'(irq), 32'd0);
    applyStimulus(BASE + 32'd4, 32'hFFFF_FFFF);
    checkReg("ovf_clr_status", BASE + 32'd4, 32'h83);

    // First frame started on the second data write; it ends 1010 edges later.
    repeat (991) tick();
    checkReg("pre_idle_status", BASE + 32'd4, 32'h83);
    applyStimulus(BASE, 32'h0000_00EE);
    checkReg("coll_status", BASE + 32'd4, 32'h8A);
    tick();
    checkReg("coll_pop_status", BASE + 32'd4, 32'h79);

    for (int c = 0; c < 12000 && rxq.size() < 9; c++) tick();
    checkOutput("rx_count", 32'(rxq.size()), 32'd9);
    while (expq.size() > 0 && rxq.size() > 0) begin
      logic [7:0] e;
      logic [7:0] r;
      e = expq.pop_front();
      r = rxq.pop_front();
      checkOutput("rx_byte", {24'd0, r}, {24'd0, e});
    end
    checkOutput("frame_err", 32'(frame_err), 32'd0);
    repeat (200) tick();
    mon_en = 1'b0;
    applyStimulus(BASE + 32'd4, 32'd0);
    checkReg("ovf_idle_status", BASE + 32'd4, 32'h04);
    checkOutput("ovf_idle_irq", 32'(irq), 32'd1);

    $display("[TB] divisor change mid-frame");
    applyStimulus(BASE + 32'd8, 32'd7);
    b = 8'hA3;
    applyStimulus(BASE, {24'd0, b});
    exp_wave.delete();
    addWave(1'b0, 8);
    addWave(b[0], 8);
    addWave(b[1], 8);
    addWave(b[2], 8);
    for (int i = 3; i < 8; i++) addWave(b[i], 2);
    addWave(1'b1, 2);
    for (int k = 0; k < exp_wave.size(); k++) begin
      if (k == 27)
        applyStimulus(BASE + 32'd8, 32'd1);
      else
        tick();
      checkOutput($sformatf("a3_tx[%0d]", k), 32'(tx), 32'(exp_wave[k]));
    end
    tick();
    checkReg("a3_idle_status", BASE + 32'd4, 32'h04);
    checkReg("a3_div", BASE + 32'd8, 32'd1);

    $display("[TB] address decode");
    ALUResult = BASE + 32'd16;
    #1;
    checkOutput("dec_hi_sel", 32'(sel), 32'd0);
    checkOutput("dec_hi_rd", ReadData, 32'd0);
    applyStimulus(BASE + 32'd16, 32'h5A);
    ALUResult = BASE - 32'd4;
    #1;
    checkOutput("dec_lo_sel", 32'(sel), 32'd0);
    applyStimulus(BASE - 32'd4, 32'h5A);
    checkReg("dec_status", BASE + 32'd4, 32'h04);
    ALUResult = BASE + 32'd12;
    #1;
    checkOutput("dec_rsv_sel", 32'(sel), 32'd1);
    checkOutput("dec_rsv_rd", ReadData, 32'd0);
    applyStimulus(BASE + 32'd12, 32'h0000_00FF);
    checkReg("dec_rsv_div", BASE + 32'd10, 32'd1);
    checkReg("dec_data_rd", BASE + 32'd3, 32'd0);
    applyStimulus(BASE + 32'd8, 32'hABCD_0005);
    checkReg("dec_div_upper", BASE + 32'd8, 32'd5);
    repeat (4) tick();
    checkOutput("dec_tx", 32'(tx), 32'd1);
    checkReg("dec_status2", BASE + 32'd7, 32'h04);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(BASE + 32'd8, 32'd3);
    applyStimulus(BASE, 32'h00);
    applyStimulus(BASE, 32'h11);
    repeat (6) tick();
    checkOutput("arst_pre_tx", 32'(tx), 32'd0);
    checkReg("arst_pre_status", BASE + 32'd4, 32'h11);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_tx", 32'(tx), 32'd1);
    checkOutput("arst_irq", 32'(irq), 32'd1);
    checkReg("arst_status", BASE + 32'd4, 32'h04);
    checkReg("arst_div", BASE + 32'd8, 32'd433);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("post_arst_tx[%0d]", k), 32'(tx), 32'd1);
    end
    checkReg("post_arst_status", BASE + 32'd4, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
